fpu_uart_host: RTL and testbench

- Host-side initiator for the FPU byte command protocol carried over UART: the far end of the FPU command controller.
- On `start`, it loads operand A into R1 and operand B into R2, issues ADD or SUB, then reads back the 3-byte result.
- Sits between an on-chip or test sequencer and a uart_tx/uart_rx pair, at the byte interface level. Used for self-test and loopback boards.

---
 rtl/fpu_uart_host.sv | 168 ++++++++++++++++
 tb/tb_fpu_uart_host.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_uart_host.sv
// Host initiator for the FPU byte protocol: loads R1/R2, issues ADD/SUB, reads a 3-byte result.
// Latency >= 10 byte sends + OP_GAP_CYCLES + 3 receptions + 1; each send waits for tx_busy low, each receive is time-limited.
module fpu_uart_host #(
    parameter int OP_GAP_CYCLES     = 64,
    parameter int RX_TIMEOUT_CYCLES = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_sub,
    input  logic        a_s,
    input  logic [6:0]  a_e,
    input  logic [14:0] a_m,
    input  logic        b_s,
    input  logic [6:0]  b_e,
    input  logic [14:0] b_m,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        res_s,
    output logic [6:0]  res_e,
    output logic [14:0] res_m
);
    localparam int TW = $clog2(RX_TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(OP_GAP_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(RX_TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(OP_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO, S_GAP, S_RECV, S_DONE
    } state_t;

    state_t         state;
    logic [3:0]     idx;
    logic [1:0]     rcnt;
    logic [TW-1:0]  tcnt;
    logic [GW-1:0]  gcnt;
    logic [22:0]    a_q;
    logic [22:0]    b_q;
    logic           op_sub_q;
    logic [7:0]     rbuf0;
    logic [7:0]     rbuf1;
    logic [7:0]     cur_byte;

    // Operand layout in a_q/b_q is {s, e[6:0], m[14:0]}.
    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            4'd0:    cur_byte = 8'h81;
            4'd1:    cur_byte = a_q[22:15];
            4'd2:    cur_byte = a_q[14:7];
            4'd3:    cur_byte = {a_q[6:0], 1'b0};
            4'd4:    cur_byte = 8'h82;
            4'd5:    cur_byte = b_q[22:15];
            4'd6:    cur_byte = b_q[14:7];
            4'd7:    cur_byte = {b_q[6:0], 1'b0};
            4'd8:    cur_byte = op_sub_q ? 8'hC0 : 8'hA0;
            4'd9:    cur_byte = 8'h90;
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            rcnt     <= '0;
            tcnt     <= '0;
            gcnt     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_sub_q <= 1'b0;
            rbuf0    <= '0;
            rbuf1    <= '0;
            tx_data  <= '0;
            tx_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            res_s    <= 1'b0;
            res_e    <= '0;
            res_m    <= '0;
        end else begin
            tx_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= {a_s, a_e, a_m};
                        b_q      <= {b_s, b_e, b_m};
                        op_sub_q <= op_sub;
                        err      <= 1'b0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_data <= cur_byte;
                        tx_en   <= 1'b1;
                        state   <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (idx == 4'd8) begin
                            gcnt  <= '0;
                            state <= S_GAP;
                        end else if (idx == 4'd9) begin
                            rcnt  <= '0;
                            tcnt  <= TMO_LOAD;
                            state <= S_RECV;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= S_SEND;
                        end
                    end
                end
                S_GAP: begin
                    if (gcnt == GAP_LAST) begin
                        idx   <= 4'd9;
                        state <= S_SEND;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                S_RECV: begin
                    // A byte arriving on the expiry cycle wins over the timeout.
                    if (rx_valid) begin
                        tcnt <= TMO_LOAD;
                        rcnt <= rcnt + 2'd1;
                        if (rcnt == 2'd0) begin
                            rbuf0 <= rx_data;
                        end else if (rcnt == 2'd1) begin
                            rbuf1 <= rx_data;
                        end else begin
                            res_s <= rbuf0[7];
                            res_e <= rbuf0[6:0];
                            res_m <= {rbuf1, rx_data[7:1]};
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (tcnt <= TW'(1)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_uart_host.sv
// Randomised scoreboard bench for fpu_uart_host with a UART transmitter model and a byte responder.
module tb_fpu_uart_host;
    localparam int GAP      = 64;
    localparam int TMO      = 300;
    localparam int BUSY_LEN = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic        a_s = 1'b0, b_s = 1'b0;
    logic [6:0]  a_e = '0, b_e = '0;
    logic [14:0] a_m = '0, b_m = '0;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        busy, done, err, res_s;
    logic [6:0]  res_e;
    logic [14:0] res_m;

    fpu_uart_host #(.OP_GAP_CYCLES(GAP), .RX_TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .op_sub(op_sub),
        .a_s(a_s), .a_e(a_e), .a_m(a_m), .b_s(b_s), .b_e(b_e), .b_m(b_m),
        .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .done(done), .err(err),
        .res_s(res_s), .res_e(res_e), .res_m(res_m)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; int b; } tx_exp_t;
    typedef struct { int err; int s; int e; int m; int kind; } done_exp_t;
    tx_exp_t   exp_tx[$];
    done_exp_t exp_done[$];
    int resp_q[$];
    int resp_mode_q[$];

    int n_checks = 0, n_fail = 0;
    int last_s = 0, last_e = 0, last_m = 0;
    int tx_count = 0, done_cnt = 0, fall_cyc = 0, stall_until = 0, t2 = 0, stray_req = 0;

    function automatic void chk(string name, int got, int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, req, cyc);
        end
    endfunction

    function automatic void chk_ge(string name, int got, int min);
        n_checks++;
        if (got < min) begin
            n_fail++;
            $display("FAIL %s: got %0d, required at least %0d (cycle %0d)", name, got, min, cyc);
        end
    endfunction

    // Transmitter model plus byte scoreboard: checks happen before tx_busy is updated this cycle.
    initial begin : tx_side
        int      bcnt;
        logic    prev_en;
        logic    nb;
        tx_exp_t x;
        bcnt = 0;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en) begin
                tx_count++;
                chk("tx_en_while_busy", int'(tx_busy), 0);
                chk("tx_en_back_to_back", int'(prev_en), 0);
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: byte 0x%0h sent with none pending", tx_data);
                end else begin
                    x = exp_tx.pop_front();
                    chk($sformatf("tx_byte%0d", x.idx), int'(tx_data), x.b);
                    if (x.idx == 9) chk_ge("op_gap", cyc - fall_cyc, GAP);
                end
                bcnt = BUSY_LEN;
            end
            prev_en = tx_en;
            nb = (bcnt > 0) || (cyc < stall_until);
            if (bcnt > 0) bcnt--;
            if (tx_busy && !nb) fall_cyc = cyc;
            tx_busy = nb;
        end
    end

    initial begin : done_mon
        done_exp_t d;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                chk("done_with_busy", int'(busy), 1);
                if (exp_done.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_unexpected: done pulse with no transaction pending");
                end else begin
                    d = exp_done.pop_front();
                    chk("done_err", int'(err), d.err);
                    chk("res_s", int'(res_s), d.s);
                    chk("res_e", int'(res_e), d.e);
                    chk("res_m", int'(res_m), d.m);
                    chk("tx_all_sent", exp_tx.size(), 0);
                    if (d.kind == 1) chk("timeout_cycle", cyc - t2, TMO + 1);
                end
            end
        end
    end

    // Replies after 0x90: mode 0 = three bytes, 1 = two bytes, 2 = third byte on the expiry cycle.
    initial begin : responder
        bit armed;
        bit go;
        int delay, sent, mode, stray_done;
        armed = 0; delay = 0; sent = 0; mode = 0; stray_done = 0;
        forever begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (reset) armed = 0;
            if (stray_req != stray_done) begin
                rx_valid = 1'b1;
                rx_data = 8'($urandom);
                stray_done++;
            end else if (armed) begin
                go = 0;
                if (mode == 2 && sent == 2) go = (cyc == t2 + TMO);
                else if (delay > 0) delay--;
                else go = 1;
                if (go && resp_q.size() > 0) begin
                    rx_valid = 1'b1;
                    rx_data = 8'(resp_q.pop_front());
                    sent++;
                    if (sent == 2) t2 = cyc;
                    delay = $urandom_range(1, 30);
                    if (sent == 3 || (mode == 1 && sent == 2)) armed = 0;
                end
            end else if (tx_en && tx_data == 8'h90 && resp_mode_q.size() > 0) begin
                armed = 1;
                mode = resp_mode_q.pop_front();
                delay = 24 + $urandom_range(0, 40);
                sent = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input int as_, input int ae_, input int am_, input int bs_, input int be_,
                         input int bm_, input int op, input int mode, input int r0, input int r1, input int r2);
        int        w[10];
        int        g;
        tx_exp_t   x;
        done_exp_t d;
        g = 0;
        while (busy && g < 20000) begin
            @(negedge clk);
            g++;
        end
        w[0] = 'h81; w[1] = as_ * 128 + ae_; w[2] = am_ / 128; w[3] = (am_ % 128) * 2;
        w[4] = 'h82; w[5] = bs_ * 128 + be_; w[6] = bm_ / 128; w[7] = (bm_ % 128) * 2;
        w[8] = op ? 'hC0 : 'hA0; w[9] = 'h90;
        for (int i = 0; i < 10; i++) begin
            x.idx = i;
            x.b = w[i];
            exp_tx.push_back(x);
        end
        resp_q.push_back(r0);
        resp_q.push_back(r1);
        if (mode != 1) resp_q.push_back(r2);
        resp_mode_q.push_back(mode);
        if (mode == 1) begin
            d = '{1, last_s, last_e, last_m, 1};
        end else begin
            last_s = r0 / 128;
            last_e = r0 % 128;
            last_m = r1 * 128 + r2 / 2;
            d = '{0, last_s, last_e, last_m, mode};
        end
        exp_done.push_back(d);
        a_s = 1'(as_); a_e = 7'(ae_); a_m = 15'(am_);
        b_s = 1'(bs_); b_e = 7'(be_); b_m = 15'(bm_);
        op_sub = 1'(op);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_e = 7'($urandom); a_m = 15'($urandom); b_e = 7'($urandom); b_m = 15'($urandom);
        op_sub = 1'($urandom);
        chk("start_clears_err", int'(err), 0);
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic issue_rand(input int mode);
        issue($urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 32767),
              $urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 32767),
              $urandom_range(0, 1), mode, $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255));
    endtask

    task automatic wait_done();
        int base;
        int g;
        base = done_cnt;
        g = 0;
        while (done_cnt == base && g < 3000 + TMO) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", int'(done_cnt != base), 1);
    endtask

    task automatic wait_tx(input int target);
        int g;
        g = 0;
        while (tx_count < target && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk_ge("tx_progress", tx_count, target);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_tx_en"}, int'(tx_en), 0);
        chk({tag, "_tx_data"}, int'(tx_data), 0);
        chk({tag, "_res_s"}, int'(res_s), 0);
        chk({tag, "_res_e"}, int'(res_e), 0);
        chk({tag, "_res_m"}, int'(res_m), 0);
    endtask

    initial begin : main
        int base;
        int mode;
        tick(3);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(2);

        issue(0, 'h05, 'h4000, 1, 'h7F, 'h7FFF, 0, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        wait_done();

        issue(0, 'h05, 'h4000, 1, 'h7F, 'h7FFF, 1, 0, 'h83, 'h12, 'h35);
        wait_done();
        chk("decode_res_s", int'(res_s), 1);
        chk("decode_res_e", int'(res_e), 'h03);
        chk("decode_res_m", int'(res_m), 'h091A);

        issue_rand(1);
        wait_done();
        tick(3);
        chk("err_held", int'(err), 1);
        chk("res_m_kept", int'(res_m), 'h091A);

        issue_rand(2);
        wait_done();

        // Transmitter busy on entry to SEND, plus stray rx_valid and a repeated start while busy.
        stall_until = cyc + 50;
        tick(2);
        base = tx_count;
        issue_rand(0);
        tick(8);
        stray_req++;
        tick(8);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(25);
        chk("tx_held_during_stall", tx_count - base, 0);
        wait_tx(base + 3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        stray_req++;
        wait_done();

        for (int k = 0; k < 6; k++) begin
            mode = $urandom_range(0, 3);
            if (mode == 3) mode = 0;
            issue_rand(mode);
            wait_done();
        end

        // Abort while waiting for byte 5 to finish, then replay from the first byte.
        base = tx_count;
        issue_rand(0);
        wait_tx(base + 6);
        tick(4);
        reset = 1'b1;
        tick(1);
        chk_all_zero("abort");
        reset = 1'b0;
        exp_tx.delete();
        exp_done.delete();
        resp_q.delete();
        resp_mode_q.delete();
        last_s = 0; last_e = 0; last_m = 0;
        tick(1);
        issue_rand(0);
        wait_done();

        tick(5);
        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
